// File: rtl/vec_pkg.sv
// Shared types and constants for the vector RAM arbiter.
package vec_pkg;

    typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_RD, AVG_HI, AVG_LO, AVG_FIN} arb_state_t;
    typedef enum logic {GRANT_AVG, GRANT_CPU} grant_t;

    localparam logic [15:0] VEC_BASE   = 16'h2000;
    localparam int          VEC_ADDR_W = 13;
    localparam logic [7:0]  OOR_BYTE   = 8'hFF;

endpackage

// File: rtl/vecram_arbiter.sv
// Round-robin sharing of one single-port vector RAM between the 6502 bus (byte access)
// and the AVG instruction fetcher (16-bit words assembled from two byte reads).
module vecram_arbiter
    import vec_pkg::*;
#(
    parameter int          ADDR_W = VEC_ADDR_W,
    parameter logic [15:0] BASE   = VEC_BASE,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              avg_req,
    input  logic [15:0]       avg_addr,
    output logic [15:0]       avg_inst,
    output logic              avg_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [CNT_W-1:0]  conflicts
);

    arb_state_t        state_q, state_d;
    grant_t            last_q, last_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_we_q, cpu_we_d;
    logic              cpu_ok_q, cpu_ok_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]        cpu_din_q, cpu_din_d;
    logic              avg_ok_q, avg_ok_d;
    logic [ADDR_W-2:0] avg_word_q, avg_word_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic [15:0]       avg_inst_q, avg_inst_d;
    logic [CNT_W-1:0]  conflicts_q, conflicts_d;

    logic [15:0] cpu_off, avg_off;
    logic        cpu_pending, cpu_served;

    function automatic logic in_range(input logic [15:0] off);
        return (32'(off) >> ADDR_W) == 32'd0;
    endfunction

    assign cpu_off   = cpu_addr - BASE;
    assign avg_off   = avg_addr - BASE;
    assign conflicts = conflicts_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cpu_pend_d  = cpu_pend_q;
        cpu_we_d    = cpu_we_q;
        cpu_ok_d    = cpu_ok_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_din_d   = cpu_din_q;
        avg_ok_d    = avg_ok_q;
        avg_word_d  = avg_word_q;
        hi_d        = hi_q;
        conflicts_d = conflicts_q;
        ram_addr    = '0;
        ram_din     = '0;
        ram_we      = 1'b0;
        cpu_ack     = 1'b0;
        avg_valid   = 1'b0;
        cpu_dout    = cpu_dout_q;
        avg_inst    = avg_inst_q;
        cpu_served  = 1'b0;
        // A strobe in the IDLE cycle is granted straight away; its operands land in the latch at the same edge.
        cpu_pending = cpu_pend_q | cpu_req;

        if (cpu_req) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = cpu_we;
            cpu_ok_d   = in_range(cpu_off);
            cpu_addr_d = cpu_off[ADDR_W-1:0];
            cpu_din_d  = cpu_din;
        end

        unique case (state_q)
            IDLE: begin
                if (cpu_pending && (!avg_req || last_q == GRANT_AVG)) begin
                    state_d    = CPU_ACC;
                    cpu_served = 1'b1;
                end else if (avg_req) begin
                    state_d    = AVG_HI;
                    avg_ok_d   = in_range(avg_off);
                    avg_word_d = avg_off[ADDR_W-1:1];
                end
            end
            CPU_ACC: begin
                ram_addr   = cpu_addr_q;
                ram_din    = cpu_din_q;
                ram_we     = cpu_we_q & cpu_ok_q;
                cpu_served = 1'b1;
                state_d    = CPU_RD;
            end
            CPU_RD: begin
                if (!cpu_we_q) cpu_dout = cpu_ok_q ? ram_dout : OOR_BYTE;
                cpu_ack    = 1'b1;
                cpu_served = 1'b1;
                if (!cpu_req) cpu_pend_d = 1'b0;
                last_d     = GRANT_CPU;
                state_d    = IDLE;
            end
            AVG_HI: begin
                ram_addr = {avg_word_q, 1'b0};
                state_d  = AVG_LO;
            end
            AVG_LO: begin
                hi_d     = avg_ok_q ? ram_dout : OOR_BYTE;
                ram_addr = {avg_word_q, 1'b1};
                state_d  = AVG_FIN;
            end
            AVG_FIN: begin
                avg_inst  = avg_ok_q ? {hi_q, ram_dout} : {OOR_BYTE, OOR_BYTE};
                avg_valid = 1'b1;
                last_d    = GRANT_AVG;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_dout_d = cpu_dout;
        avg_inst_d = avg_inst;
        if (cpu_pending && avg_req && !cpu_served && !(&conflicts_q))
            conflicts_d = conflicts_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= GRANT_AVG;
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_ok_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_din_q   <= '0;
            avg_ok_q    <= 1'b0;
            avg_word_q  <= '0;
            hi_q        <= '0;
            cpu_dout_q  <= '0;
            avg_inst_q  <= '0;
            conflicts_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cpu_pend_q  <= cpu_pend_d;
            cpu_we_q    <= cpu_we_d;
            cpu_ok_q    <= cpu_ok_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_din_q   <= cpu_din_d;
            avg_ok_q    <= avg_ok_d;
            avg_word_q  <= avg_word_d;
            hi_q        <= hi_d;
            cpu_dout_q  <= cpu_dout_d;
            avg_inst_q  <= avg_inst_d;
            conflicts_q <= conflicts_d;
        end
    end

endmodule

// File: tb/tb_vecram_arbiter.sv
// Bench for vecram_arbiter: directed scenarios plus randomized traffic against a shadow-memory model.
module tb_vecram_arbiter;

    localparam int          AW   = 13;
    localparam logic [15:0] BASE = 16'h2000;
    localparam int          CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0]   cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          avg_req = 1'b0;
    logic [15:0]   avg_addr = '0;
    logic [15:0]   avg_inst;
    logic          avg_valid;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [CW-1:0] conflicts;

    always #5 clk = ~clk;

    vecram_arbiter #(.ADDR_W(AW), .BASE(BASE), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .avg_req(avg_req), .avg_addr(avg_addr), .avg_inst(avg_inst), .avg_valid(avg_valid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .conflicts(conflicts)
    );

    // External sp_ram: synchronous read, one cycle latency.
    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic       preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= ref_mem[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int offs(input logic [15:0] a);
        return int'(a) - int'(BASE);
    endfunction

    function automatic bit in_rng(input logic [15:0] a);
        return offs(a) >= 0 && offs(a) < (1 << AW);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        return in_rng(a) ? ref_mem[offs(a)] : 8'hFF;
    endfunction

    function automatic logic [15:0] exp_avg(input logic [15:0] a);
        int w;
        w = offs(a) & ~1;
        return in_rng(a) ? {ref_mem[w], ref_mem[w+1]} : 16'hFFFF;
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 15))
            0:       return 16'($urandom);
            1:       return BASE + 16'd8191;
            2:       return BASE + 16'd8192;
            3:       return BASE - 16'd1;
            default: return BASE + 16'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic cpu_solo(input bit we, input logic [15:0] a, input logic [7:0] d,
                            output int ack_at, output int we_cnt, output logic [15:0] we_addr,
                            output logic [7:0] we_data, output logic [7:0] dout);
        ack_at = -1; we_cnt = 0; we_addr = '0; we_data = '0; dout = '0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_we) begin we_cnt++; we_addr = 16'(ram_addr); we_data = ram_din; end
            if (cpu_ack && ack_at < 0) begin ack_at = k; dout = cpu_dout; end
            @(posedge clk); #1;
            cpu_req = 1'b0;
        end
        if (we && in_rng(a)) ref_mem[offs(a)] = d;
    endtask

    task automatic avg_solo(input logic [15:0] a, output int val_at, output logic [15:0] inst,
                            output int we_cnt);
        val_at = -1; inst = '0; we_cnt = 0;
        @(posedge clk); #1;
        avg_req = 1'b1; avg_addr = a;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
            if (avg_valid && val_at < 0) begin val_at = k; inst = avg_inst; end
            @(posedge clk); #1;
            if (val_at >= 0) avg_req = 1'b0;
        end
        avg_req = 1'b0;
    endtask

    // Traffic engine: one outstanding op per requester; cont keeps both always requesting.
    task automatic engine(input int ncyc, input bit cont);
        int            cpu_t, avg_t, last_evt;
        bit            cpu_busy, avg_busy, op_we;
        logic [15:0]   op_addr, a_addr;
        logic [7:0]    op_din;
        logic [CW-1:0] prev_conf;
        cpu_busy = 0; avg_busy = 0; last_evt = 0; cpu_t = 0; avg_t = 0;
        op_we = 0; op_addr = '0; a_addr = '0; op_din = '0;
        prev_conf = conflicts;
        for (int c = 0; c < ncyc + 16; c++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            if (c < ncyc && !cpu_busy && (cont || $urandom_range(0, 3) == 0)) begin
                op_we = 1'($urandom_range(0, 1)); op_addr = pick_addr(); op_din = 8'($urandom);
                cpu_req = 1'b1; cpu_we = op_we; cpu_addr = op_addr; cpu_din = op_din;
                cpu_busy = 1; cpu_t = c;
            end
            if (!avg_busy) begin
                if (c < ncyc && (cont || $urandom_range(0, 3) == 0)) begin
                    a_addr = pick_addr(); avg_req = 1'b1; avg_addr = a_addr;
                    avg_busy = 1; avg_t = c;
                end else begin
                    avg_req = 1'b0;
                end
            end
            @(negedge clk);
            chk("conflicts_monotone", 32'(conflicts >= prev_conf), 32'd1);
            prev_conf = conflicts;
            if (cpu_ack) begin
                chk("cpu_ack_outstanding", 32'(cpu_busy), 32'd1);
                chk("cpu_latency_le6", 32'(c - cpu_t <= 6), 32'd1);
                if (!op_we) chk("cpu_rd_data", 32'(cpu_dout), 32'(exp_rd(op_addr)));
                else if (in_rng(op_addr)) ref_mem[offs(op_addr)] = op_din;
                if (cont && last_evt != 0) chk("alternate_to_cpu", 32'(last_evt), 32'd2);
                last_evt = 1; cpu_busy = 0;
            end
            if (avg_valid) begin
                chk("avg_valid_outstanding", 32'(avg_busy), 32'd1);
                chk("avg_inst_data", 32'(avg_inst), 32'(exp_avg(a_addr)));
                if (cont && last_evt != 0) chk("alternate_to_avg", 32'(last_evt), 32'd1);
                last_evt = 2; avg_busy = 0;
            end
            if (cpu_busy && c - cpu_t > 12) begin chk("cpu_timeout_cycles", 32'(c - cpu_t), 32'd6); cpu_busy = 0; end
            if (avg_busy && c - avg_t > 12) begin chk("avg_timeout_cycles", 32'(c - avg_t), 32'd6); avg_busy = 0; end
        end
        cpu_req = 1'b0; avg_req = 1'b0;
    endtask

    initial begin
        int          ack_at, val_at, we_cnt, seen;
        logic [15:0] we_addr, inst;
        logic [7:0]  we_data, dout;

        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 8'($urandom);
        ref_mem[16'h011] = 8'h3C;

        #1 rst = 1'b1;
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_avg_valid", 32'(avg_valid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst_avg_inst", 32'(avg_inst), 32'd0);
        chk("rst_conflicts", 32'(conflicts), 32'd0);
        @(posedge clk); #1 preload = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // CPU write into idle arbiter
        cpu_solo(1'b1, 16'h2010, 8'hA5, ack_at, we_cnt, we_addr, we_data, dout);
        chk("wr_ack_latency", 32'(ack_at), 32'd2);
        chk("wr_we_cycles", 32'(we_cnt), 32'd1);
        chk("wr_ram_addr", 32'(we_addr), 32'h010);
        chk("wr_ram_din", 32'(we_data), 32'hA5);

        // AVG fetch of the written word
        avg_solo(16'h2010, val_at, inst, we_cnt);
        chk("avg_latency", 32'(val_at), 32'd3);
        chk("avg_inst_a53c", 32'(inst), 32'hA53C);
        chk("avg_no_we", 32'(we_cnt), 32'd0);

        // CPU read so that the CPU was granted last
        cpu_solo(1'b0, 16'h2011, 8'h00, ack_at, we_cnt, we_addr, we_data, dout);
        chk("rd_ack_latency", 32'(ack_at), 32'd2);
        chk("rd_data", 32'(dout), 32'(exp_rd(16'h2011)));

        // Simultaneous requests: AVG wins after a CPU grant
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2010;
        avg_req = 1'b1; avg_addr = 16'h2011;
        ack_at = -1; val_at = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (avg_valid && val_at < 0) begin val_at = k; inst = avg_inst; end
            if (cpu_ack && ack_at < 0) begin ack_at = k; dout = cpu_dout; end
            @(posedge clk); #1;
            cpu_req = 1'b0;
            if (val_at >= 0) avg_req = 1'b0;
        end
        chk("conf_avg_latency", 32'(val_at), 32'd3);
        chk("conf_avg_inst", 32'(inst), 32'(exp_avg(16'h2011)));
        chk("conf_cpu_after_avg", 32'(ack_at > val_at && ack_at <= 6), 32'd1);
        chk("conf_cpu_data", 32'(dout), 32'(exp_rd(16'h2010)));
        chk("conf_counted", 32'(conflicts >= 1), 32'd1);

        // Out-of-range accesses
        cpu_solo(1'b0, 16'h4000, 8'h00, ack_at, we_cnt, we_addr, we_data, dout);
        chk("oor_rd_ack", 32'(ack_at), 32'd2);
        chk("oor_rd_no_we", 32'(we_cnt), 32'd0);
        chk("oor_rd_ff", 32'(dout), 32'hFF);
        cpu_solo(1'b1, 16'h4005, 8'h5A, ack_at, we_cnt, we_addr, we_data, dout);
        chk("oor_wr_ack", 32'(ack_at), 32'd2);
        chk("oor_wr_no_we", 32'(we_cnt), 32'd0);
        avg_solo(16'h1FFE, val_at, inst, we_cnt);
        chk("oor_avg_latency", 32'(val_at), 32'd3);
        chk("oor_avg_ffff", 32'(inst), 32'hFFFF);

        // Reset in the middle of a fetch
        @(posedge clk); #1; avg_req = 1'b1; avg_addr = 16'h2010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_lo_addr", 32'(ram_addr), 32'h011);
        rst = 1'b1; #1;
        chk("mid_rst_avg_valid", 32'(avg_valid), 32'd0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_avg_inst", 32'(avg_inst), 32'd0);
        chk("mid_rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("mid_rst_conflicts", 32'(conflicts), 32'd0);
        avg_req = 1'b0; seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (avg_valid) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        avg_solo(16'h2010, val_at, inst, we_cnt);
        chk("post_rst_latency", 32'(val_at), 32'd3);
        chk("post_rst_inst", 32'(inst), 32'(exp_avg(16'h2010)));

        // Both requesters held continuously
        engine(10000, 1'b1);
        chk("cont_conflicts_nonzero", 32'(conflicts > 0), 32'd1);

        // Randomized mixed traffic
        engine(3000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
